light_decoder: RTL
==================

# light_decoder

Receive-side counterpart of the `lightcontrol` encoder. Samples the 6-bit light pattern `l_in` produced by `lightcontrol` (possibly from an asynchronous source). Debounces it, decodes it back to the 3-bit code, and presents each newly accepted code on a valid/ready output with a 1-deep pending buffer. It also flags illegal and ambiguous patterns and keeps a saturating error count.

## Interface
- `STABLE_CYCLES`, default 4 (legal range 1..255): consecutive identical synchronized samples required to accept a pattern.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `l_in`  in  6  raw light pattern, bit `l_in[i]` = lamp `i`; asynchronous to `clk`.
- `code`  out  3  decoded code; 0 when `illegal`.
- `valid`  out  1  output holds an accepted event.
- `ready`  in  1  consumer accepts the event when `valid & ready` at a rising edge.
- `illegal`  out  1  the event's pattern is not in the code table; qualified by `valid`.
- `ambig`  out  1  the event's pattern maps to more than one code; qualified by `valid`.
- `overrun`  out  1  one-cycle pulse when the pending event is overwritten.
- `err_cnt`  out  8  count of illegal events; saturates at 255.
- `clr_err`  in  1  synchronous clear of `err_cnt`.

## Operation
- Code table (`l[5:0]` → code):
  - 000000→0, 111111→1, 010101→2, 110001→3, 111001→4, 101001→5 (ambig; also produced by code 7), 001001→6.
  - Every other pattern is illegal.
- Synchronizer: two flops, `s1` then `s2`.
- Stability counter:
  - Resets to 1 when `s2` differs from its previous value; otherwise increments, saturating at `STABLE_CYCLES`.
  - The pattern is accepted in the single cycle in which the counter reaches `STABLE_CYCLES`.
- Accepted pattern equal to `last_acc` → no event.
- Accepted pattern different from `last_acc`:
  - `last_acc` is updated.
  - The event is decoded into {`code`, `illegal`, `ambig`}.
  - An illegal event increments `err_cnt` (saturating).
- Output state machine:
  - EMPTY: `valid`=0. A new event loads the output register → SHOW.
  - SHOW: `valid`=1 with outputs stable.
    - Handshake with no new event → EMPTY.
    - Handshake and new event in the same cycle → the new event loads the output, stay SHOW.
    - New event without handshake → the event goes to the pending register → SHOW_PEND.
  - SHOW_PEND: `valid`=1 with the output unchanged.
    - Handshake → pending moves to the output → SHOW.
    - New event without handshake → pending is overwritten and `overrun` pulses.
    - Handshake and new event together → pending moves to the output, the new event moves to pending, no overrun.
- `clr_err` and an increment in the same cycle → `err_cnt` = 0.
- Reset values:
  - `code`=0, `valid`=0, `illegal`=0, `ambig`=0, `overrun`=0, `err_cnt`=0.
  - `s1`=`s2`=`last_acc`=000000, counter=`STABLE_CYCLES` (saturated), state EMPTY.
  - With these values, a dark input after reset produces no event.
- Reset mid-operation discards the pending and output events immediately.

## Timing
- Event latency:
  - Count edge 1 as the first edge that samples a new stable `l_in`.
  - `valid` is high after edge `STABLE_CYCLES`+2, i.e. edge 6 with the default.
- A change shorter than `STABLE_CYCLES` cycles at `s2` is filtered: no event, no count.
- Throughput: one event per `STABLE_CYCLES` cycles at most; one output transfer per cycle.
- `err_cnt` updates on the same edge that loads the event (into the output or pending register).
- `overrun` is high for exactly one cycle, the cycle after the overwrite edge.

## Structure
- Shared package `light_pkg` holds:
  - Typedefs `light_t` (6 bits) and `code_t` (3 bits).
  - Pattern constants `LP_C0..LP_C6`.
  - Function `light_decode(light_t) → {code, illegal, ambig}`, also usable by the bench.
- One sub-module, `light_debounce`: synchronizer, stability counter and `last_acc` compare. Outputs an `event` pulse plus the `light_t` pattern.
- Top-level `light_decoder` holds the decode, the output/pending state machine and the error counter.

## Test plan
- Reset with `l_in`=000000, hold 20 cycles → `valid` stays 0, `err_cnt`=0.
- `l_in` = 111111, 010101, 110001, 111001, 001001 in sequence, each held 10 cycles, `ready`=1 → codes 1, 2, 3, 4, 6 in that order, each `valid` rising 6 edges after its change, `illegal`=0.
- `l_in`=101001 → `code`=5, `ambig`=1. Then `l_in`=000011 → `illegal`=1, `code`=0, `err_cnt`=1.
- 3-cycle pulse of 111111 on a 000000 background (`STABLE_CYCLES`=4) → no event.
- `ready`=0; apply 111111, then 010101, then 110001 → output shows code 1; `overrun` pulses once when 110001 overwrites 010101. Raising `ready` delivers 1 then 3, then `valid`=0.
- 300 alternating illegal patterns (000011 / 000111) → `err_cnt`=255. `clr_err` → 0. Assert `rst_n` low while in SHOW_PEND → `valid`=0 at once, and no event after release.

Source files
------------

// File: rtl/light_pkg.sv
// Shared types, pattern constants and the pattern-to-code decode used by the
// light_decoder receive path (and available to benches).
package light_pkg;

   typedef logic [5:0] light_t;
   typedef logic [2:0] code_t;

   typedef struct packed {
      code_t code;
      logic  illegal;
      logic  ambig;
   } dec_t;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_SHOW,
      ST_SHOW_PEND
   } ostate_t;

   localparam light_t LP_C0 = 6'b000000;
   localparam light_t LP_C1 = 6'b111111;
   localparam light_t LP_C2 = 6'b010101;
   localparam light_t LP_C3 = 6'b110001;
   localparam light_t LP_C4 = 6'b111001;
   localparam light_t LP_C5 = 6'b101001;
   localparam light_t LP_C6 = 6'b001001;

   localparam logic [7:0] ERR_MAX = 8'hff;

   // Code 7 is encoded with the same lamps as code 5, so 5 is reported as ambiguous.
   function automatic dec_t light_decode(input light_t l);
      dec_t d;
      d.code    = 3'd0;
      d.illegal = 1'b0;
      d.ambig   = 1'b0;
      case (l)
         LP_C0:   d.code = 3'd0;
         LP_C1:   d.code = 3'd1;
         LP_C2:   d.code = 3'd2;
         LP_C3:   d.code = 3'd3;
         LP_C4:   d.code = 3'd4;
         LP_C5: begin
            d.code  = 3'd5;
            d.ambig = 1'b1;
         end
         LP_C6:   d.code = 3'd6;
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/light_debounce.sv
// Two-flop synchronizer, stability counter and last-accepted compare.
// Emits a one-cycle evt pulse with the newly accepted pattern.
module light_debounce
   import light_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)
(
   input  logic   clk,
   input  logic   rst_n,
   input  light_t l_in,
   output logic   evt,
   output light_t pattern
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   light_t     s1_reg;
   light_t     s2_reg;
   light_t     last_acc_reg;
   logic [7:0] cnt_reg;
   logic [7:0] cnt_next;
   logic       hit_reg;
   logic       hit_next;
   logic       changed;

   // The counter tracks the value s2 is about to take, so hit_reg lines up with s2.
   always_comb begin
      changed  = (s1_reg != s2_reg);
      cnt_next = cnt_reg;
      if (changed) begin
         cnt_next = 8'd1;
      end else if (cnt_reg != STABLE) begin
         cnt_next = cnt_reg + 8'd1;
      end
      hit_next = (cnt_next == STABLE) && (changed || (cnt_reg != STABLE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg       <= '0;
         s2_reg       <= '0;
         cnt_reg      <= STABLE;
         hit_reg      <= 1'b0;
         last_acc_reg <= '0;
      end else begin
         s1_reg  <= l_in;
         s2_reg  <= s1_reg;
         cnt_reg <= cnt_next;
         hit_reg <= hit_next;
         if (evt) begin
            last_acc_reg <= s2_reg;
         end
      end
   end

   assign evt     = hit_reg && (s2_reg != last_acc_reg);
   assign pattern = s2_reg;

endmodule

// File: rtl/light_decoder.sv
// Receive-side decoder for lightcontrol patterns: debounce, decode, and a
// valid/ready output with a one-deep pending buffer plus error counting.
module light_decoder
   import light_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] l_in,
   output logic [2:0] code,
   output logic       valid,
   input  logic       ready,
   output logic       illegal,
   output logic       ambig,
   output logic       overrun,
   output logic [7:0] err_cnt,
   input  logic       clr_err
);

   logic       evt;
   light_t     pattern;
   dec_t       dec;

   ostate_t    state_reg;
   ostate_t    state_next;
   dec_t       out_reg;
   dec_t       out_next;
   dec_t       pend_reg;
   dec_t       pend_next;
   logic       overrun_reg;
   logic       overrun_next;
   logic [7:0] err_reg;
   logic [7:0] err_next;
   logic       hs;

   light_debounce #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .l_in    (l_in),
      .evt     (evt),
      .pattern (pattern)
   );

   assign dec = light_decode(pattern);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      out_next     = out_reg;
      pend_next    = pend_reg;
      overrun_next = 1'b0;
      hs           = (state_reg != ST_EMPTY) && ready;
      case (state_reg)
         ST_EMPTY: begin
            if (evt) begin
               out_next   = dec;
               state_next = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (hs && evt) begin
               out_next = dec;
            end else if (hs) begin
               state_next = ST_EMPTY;
            end else if (evt) begin
               pend_next  = dec;
               state_next = ST_SHOW_PEND;
            end
         end
         ST_SHOW_PEND: begin
            if (hs) begin
               out_next = pend_reg;
               if (evt) begin
                  pend_next = dec;
               end else begin
                  state_next = ST_SHOW;
               end
            end else if (evt) begin
               pend_next    = dec;
               overrun_next = 1'b1;
            end
         end
         default: state_next = ST_EMPTY;
      endcase

      // Clear wins over a coincident increment.
      err_next = err_reg;
      if (clr_err) begin
         err_next = 8'd0;
      end else if (evt && dec.illegal && (err_reg != ERR_MAX)) begin
         err_next = err_reg + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg     <= '0;
         pend_reg    <= '0;
         overrun_reg <= 1'b0;
         err_reg     <= 8'd0;
      end else begin
         out_reg     <= out_next;
         pend_reg    <= pend_next;
         overrun_reg <= overrun_next;
         err_reg     <= err_next;
      end
   end

   assign valid   = (state_reg != ST_EMPTY);
   assign code    = out_reg.code;
   assign illegal = out_reg.illegal;
   assign ambig   = out_reg.ambig;
   assign overrun = overrun_reg;
   assign err_cnt = err_reg;

endmodule
